cust_queue_v2: RTL and testbench
================================

Name: cust_queue_v2

Overview:
Parametrised successor of the customer-waiting FIFO in the counter-service design. Holds {customer number, service time} pairs between the arrival generator and the counter dispatcher. Adds any-DEPTH circular addressing, occupancy count, almost-full flag, simultaneous enqueue/dequeue when full, synchronous flush, and sticky overflow/underflow error flags.

Parameters:
DT_SZ, 4, width of each field (number and time)
DEPTH, 3, number of entries; any integer >= 2, power of two not required
AF_LVL, 2, almost-full threshold; afull=1 when count >= AF_LVL (1..DEPTH)
(derived localparams: PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of queue contents and error flags
we  in  1  enqueue request
dn  in  DT_SZ  customer number to enqueue
dt  in  DT_SZ  service time to enqueue
re  in  1  dequeue request
qn  out  DT_SZ  head customer number (0 when empty)
qt  out  DT_SZ  head service time (0 when empty)
cnt  out  CNT_W  current occupancy 0..DEPTH
full  out  1  cnt == DEPTH
empty  out  1  cnt == 0
afull  out  1  cnt >= AF_LVL
ovf  out  1  sticky: enqueue dropped because queue full
udf  out  1  sticky: dequeue requested while empty

Behaviour:
- Reset (rst_n=0, async): hd=tl=0, cnt=0, all storage 0, ovf=udf=0. Outputs: qn=qt=0, cnt=0, empty=1, full=0, afull=0, ovf=udf=0.
- All state updates on rising clk; qn/qt/full/empty/afull are combinational from registered state (zero-latency head view).
- Dequeue accepted (rd_ok) = re && !empty.
- Enqueue accepted (wr_ok) = we && (!full || rd_ok); full plus simultaneous read frees one slot and both complete in the same cycle.
- No write-through: enqueue into empty queue becomes visible on qn/qt the next cycle; re in that same cycle is an underflow.
- wr_ok: storage[tl] <= {dn,dt}; tl <= (tl==DEPTH-1) ? 0 : tl+1.
- rd_ok: hd <= (hd==DEPTH-1) ? 0 : hd+1. Popped slot contents are not cleared.
- cnt: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- ovf <= 1 when we && full && !rd_ok. Entry is dropped; state otherwise unchanged.
- udf <= 1 when re && empty. No pointer movement.
- Once set, ovf and udf hold until flush or reset.
- flush has highest priority: hd=tl=cnt=0, ovf=udf=0, and we/re ignored that cycle. Storage is not cleared, but qn/qt read 0 because the queue is empty.
- Reset asserted mid-operation discards all contents immediately, with no clock required.
- cnt never exceeds DEPTH and never wraps below 0.

Optional Feature:
Macro CQ_DBG_EN.
- Defined: extra output port qdbg [DEPTH*2*DT_SZ-1:0], a combinational snapshot for waveform viewing.
  - Valid entries are packed oldest at the MSBs, each as {num,time}.
  - Slots beyond cnt read 0.
  - Depends on storage, hd and cnt; updates whenever any of them change.
- Not defined: qdbg port and its logic are absent. All other behaviour is identical.

Test Plan:
Reset then enqueue (1,5),(2,3) on consecutive cycles -> cnt=2, afull=1, full=0, qn=1, qt=5; one re -> qn=2, qt=3, cnt=1.
Fill DEPTH=3 with (1,1),(2,2),(3,3), then we=1 with (4,4), re=0 -> full=1, ovf=1, cnt stays 3; dequeue three times yields 1,2,3 in order.
Full queue, we=1 (5,5) and re=1 in the same cycle -> cnt stays 3, head advances, (5,5) dequeued last; ovf unchanged.
Wrap: 7 enqueue/dequeue pairs interleaved at DEPTH=3 -> data order preserved across pointer wrap at index 2->0; cnt never exceeds 3.
Empty queue, re=1 -> udf=1, qn=qt=0, cnt=0; then flush=1 with we=1 in the same cycle -> udf=0, cnt=0, write ignored.
Assert rst_n low asynchronously mid-cycle with 2 entries queued -> empty=1, cnt=0, qn=qt=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/cust_queue_v2.sv
// cust_queue_v2: {customer number, service time} FIFO, any DEPTH, with flags.
// Define CQ_DBG_EN to add the qdbg occupancy snapshot port.
module cust_queue_v2 #(
  parameter int DT_SZ  = 4,
  parameter int DEPTH  = 3,
  parameter int AF_LVL = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             we,
  input  logic [DT_SZ-1:0] dn,
  input  logic [DT_SZ-1:0] dt,
  input  logic             re,
  output logic [DT_SZ-1:0] qn,
  output logic [DT_SZ-1:0] qt,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             ovf,
  output logic             udf
`ifdef CQ_DBG_EN
  ,
  output logic [DEPTH*2*DT_SZ-1:0] qdbg
`endif
);

  localparam int EW = 2*DT_SZ;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] hd_q, hd_d;
  logic [PTR_W-1:0] tl_q, tl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_ok, wr_ok;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign cnt   = cnt_q;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign afull = (cnt_q >= CNT_W'(AF_LVL));
  assign ovf   = ovf_q;
  assign udf   = udf_q;
  assign qn    = empty ? '0 : mem_q[hd_q][EW-1 -: DT_SZ];
  assign qt    = empty ? '0 : mem_q[hd_q][DT_SZ-1:0];

  // A pop frees a slot, so a full queue still accepts a same-cycle push.
  assign rd_ok = re && !empty;
  assign wr_ok = we && (!full || rd_ok);

  always_comb begin
    mem_d = mem_q;
    hd_d  = hd_q;
    tl_d  = tl_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush) begin
      hd_d  = '0;
      tl_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[tl_q] = {dn, dt};
        tl_d = nxt(tl_q);
      end
      if (rd_ok) hd_d = nxt(hd_q);
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (we && full && !rd_ok) ovf_d = 1'b1;
      if (re && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

`ifdef CQ_DBG_EN
  // Oldest valid entry lands in the top slot; unused slots read zero.
  always_comb begin
    int idx;
    qdbg = '0;
    idx  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = int'(hd_q) + i;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if (i < int'(cnt_q))
        qdbg[(DEPTH-1-i)*EW +: EW] = mem_q[idx[PTR_W-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_cust_queue_v2.sv
// tb_cust_queue_v2: vector table, hand sequences and random run
// against a queue-based reference model of cust_queue_v2.
module tb_cust_queue_v2;
  localparam int DEPTH  = 3;
  localparam int AF_LVL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [3:0] dn = '0;
  logic [3:0] dt = '0;
  logic [3:0] qn, qt;
  logic [1:0] cnt;
  logic       full, empty, afull, ovf, udf;
`ifdef CQ_DBG_EN
  logic [23:0] qdbg;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  cust_queue_v2 #(.DT_SZ(4), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .we(we), .dn(dn), .dt(dt), .re(re),
    .qn(qn), .qt(qt), .cnt(cnt),
    .full(full), .empty(empty), .afull(afull),
    .ovf(ovf), .udf(udf)
`ifdef CQ_DBG_EN
    , .qdbg(qdbg)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {qn, qt, cnt, full, empty, afull, ovf, udf};
  endfunction

  function automatic logic [14:0] e(int a, int b, int c, int fl,
                                    int em, int af, int o, int u);
    return {4'(a), 4'(b), 2'(c), 1'(fl), 1'(em), 1'(af), 1'(o), 1'(u)};
  endfunction

  function automatic logic [14:0] mexp();
    logic [3:0] en;
    logic [3:0] et;
    int n;
    n  = mq.size();
    en = '0;
    et = '0;
    if (n > 0) begin
      en = mq[0][7:4];
      et = mq[0][3:0];
    end
    return {en, et, 2'(n), 1'(n == DEPTH), 1'(n == 0),
            1'(n >= AF_LVL), m_ovf, m_udf};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_step(bit f, bit w, logic [7:0] d, bit r);
    int n;
    bit rd, wr;
    n = mq.size();
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd = r && (n > 0);
      wr = w && ((n < DEPTH) || rd);
      if (w && n == DEPTH && !rd) m_ovf = 1'b1;
      if (r && n == 0) m_udf = 1'b1;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(d);
    end
  endtask

  task automatic step(bit f, bit w, logic [3:0] n_, logic [3:0] t_, bit r);
    flush = f;
    we    = w;
    dn    = n_;
    dt    = t_;
    re    = r;
    @(posedge clk);
    model_step(f, w, {n_, t_}, r);
    #1;
    flush = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
  endtask

  typedef struct {
    bit f;
    bit w;
    logic [3:0] n;
    logic [3:0] t;
    bit r;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [23:0] dexp;
    bit f, w, r;
    int pw;

    vecs[0]  = '{0, 1, 4'd1, 4'd5, 0, e(1, 5, 1, 0, 0, 0, 0, 0)};
    vecs[1]  = '{0, 1, 4'd2, 4'd3, 0, e(1, 5, 2, 0, 0, 1, 0, 0)};
    vecs[2]  = '{0, 0, 4'd0, 4'd0, 1, e(2, 3, 1, 0, 0, 0, 0, 0)};
    vecs[3]  = '{0, 0, 4'd0, 4'd0, 1, e(0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[4]  = '{0, 1, 4'd1, 4'd1, 0, e(1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[5]  = '{0, 1, 4'd2, 4'd2, 0, e(1, 1, 2, 0, 0, 1, 0, 0)};
    vecs[6]  = '{0, 1, 4'd3, 4'd3, 0, e(1, 1, 3, 1, 0, 1, 0, 0)};
    vecs[7]  = '{0, 1, 4'd4, 4'd4, 0, e(1, 1, 3, 1, 0, 1, 1, 0)};
    vecs[8]  = '{0, 1, 4'd5, 4'd5, 1, e(2, 2, 3, 1, 0, 1, 1, 0)};
    vecs[9]  = '{0, 0, 4'd0, 4'd0, 1, e(3, 3, 2, 0, 0, 1, 1, 0)};
    vecs[10] = '{0, 0, 4'd0, 4'd0, 1, e(5, 5, 1, 0, 0, 0, 1, 0)};
    vecs[11] = '{0, 0, 4'd0, 4'd0, 1, e(0, 0, 0, 0, 1, 0, 1, 0)};
    vecs[12] = '{0, 0, 4'd0, 4'd0, 1, e(0, 0, 0, 0, 1, 0, 1, 1)};
    vecs[13] = '{1, 1, 4'd9, 4'd9, 1, e(0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[14] = '{0, 1, 4'd6, 4'd6, 1, e(6, 6, 1, 0, 0, 0, 0, 1)};
    vecs[15] = '{1, 0, 4'd0, 4'd0, 0, e(0, 0, 0, 0, 1, 0, 0, 0)};

    repeat (2) @(posedge clk);
    #1;
    check("reset", obs(), e(0, 0, 0, 0, 1, 0, 0, 0));
    #3 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].f, vecs[i].w, vecs[i].n, vecs[i].t, vecs[i].r);
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Pointer wrap: one entry in flight, seven push/pop pairs
    step(0, 1, 4'd0, 4'd15, 0);
    check("wrap_pre", obs(), mexp());
    for (int k = 1; k <= 7; k++) begin
      step(0, 1, 4'(k), 4'(15 - k), 1);
      check($sformatf("wrap%0d", k), {qn, qt, cnt},
            {4'(k), 4'(15 - k), 2'd1});
    end
    step(0, 0, 4'd0, 4'd0, 1);
    check("wrap_end", obs(), e(0, 0, 0, 0, 1, 0, 0, 0));

    // Asynchronous reset with two entries queued
    step(0, 1, 4'd10, 4'd1, 0);
    step(0, 1, 4'd11, 4'd2, 0);
    check("pre_arst", obs(), e(10, 1, 2, 0, 0, 1, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check("arst", obs(), e(0, 0, 0, 0, 1, 0, 0, 0));
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #3 rst_n = 1'b1;
    step(0, 1, 4'd7, 4'd8, 0);
    check("post_arst", obs(), e(7, 8, 1, 0, 0, 0, 0, 0));

    // Random traffic, write-heavy then read-heavy phases
    for (int c = 0; c < 600; c++) begin
      pw = (c < 300) ? 70 : 35;
      f = ($urandom_range(0, 39) == 0);
      w = ($urandom_range(0, 99) < pw);
      r = ($urandom_range(0, 99) < (100 - pw));
      step(f, w, 4'($urandom), 4'($urandom), r);
      check("rand", obs(), mexp());
`ifdef CQ_DBG_EN
      dexp = '0;
      for (int j = 0; j < mq.size(); j++)
        dexp[(DEPTH-1-j)*8 +: 8] = mq[j];
      check("qdbg", qdbg, dexp);
`else
      dexp = '0;
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
